int_ctrl_nested: RTL

//   Parametrised vectored interrupt controller for the single-cycle CPU. Replaces the flat 8-line int_e sampling:

---
 rtl/int_ctrl_pkg.sv | 15 +
 rtl/int_ctrl_nested_isr_stack.sv | 68 ++++++
 rtl/int_ctrl_nested.sv | 136 +++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and default widths for the nested interrupt controller.
// State codes and the id/level widths of the default configuration.
package int_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam int N_IRQ_DEF      = 8;
  localparam int NEST_DEPTH_DEF = 4;
  localparam int IRQ_ID_W       = $clog2(N_IRQ_DEF);
  localparam int NEST_W         = $clog2(NEST_DEPTH_DEF) + 1;

endpackage

// File: rtl/int_ctrl_nested_isr_stack.sv
// LIFO of in-service interrupt ids.
// A pop and a push in the same cycle replace the top entry.
module isr_stack
  import int_ctrl_pkg::*;
#(
  parameter int DEPTH = NEST_DEPTH_DEF,
  parameter int ID_W  = IRQ_ID_W,
  parameter int CNT_W = NEST_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] push_id,
  output logic [ID_W-1:0] top_id,
  output logic [CNT_W-1:0] count,
  output logic            empty,
  output logic            full
);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [ID_W-1:0]  mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] wr_idx;
  logic             do_pop;
  logic             do_push;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;

  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_idx  = do_pop ? cnt_q - 1'b1 : cnt_q;
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) mem_d[i] = push_id;
      end
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    top_id = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i + 1) == cnt_q) top_id = mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/int_ctrl_nested.sv
// Vectored interrupt controller with edge capture, masking,
// fixed priority and nested servicing via an in-service stack.
module int_ctrl_nested
  import int_ctrl_pkg::*;
#(
  parameter int                N_IRQ      = N_IRQ_DEF,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0F00,
  parameter int                VEC_STRIDE = 4,
  parameter int                NEST_DEPTH = NEST_DEPTH_DEF,
  localparam int               ID_W       = $clog2(N_IRQ),
  localparam int               LVL_W      = $clog2(NEST_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  int_e,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_din,
  output logic [N_IRQ-1:0]  mask_q,
  output logic              irq_req,
  output logic [ADDR_W-1:0] irq_vec,
  output logic [ID_W-1:0]   irq_id,
  input  logic              irq_ack,
  input  logic              reti,
  output logic [LVL_W-1:0]  nest_lvl,
  output logic              err_uflow
);

  state_e            state_q, state_d;
  logic [N_IRQ-1:0]  prev_q;
  logic [N_IRQ-1:0]  pend_q, pend_d;
  logic [N_IRQ-1:0]  mask_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              err_q, err_d;
  logic [N_IRQ-1:0]  elig;
  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic              accept;
  logic              take;
  logic [ID_W-1:0]   top_id;
  logic              stk_empty;
  logic              stk_full;

  assign elig = pend_q & mask_q;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  // Only strictly higher priority than the running handler may preempt.
  assign accept = win_vld && !stk_full &&
                  (stk_empty || (win_id < top_id));
  assign take   = (state_q == REQ) && irq_ack;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          state_d = REQ;
          id_d    = win_id;
          vec_d   = VEC_BASE +
                    ADDR_W'(win_id) * ADDR_W'(VEC_STRIDE);
        end
      end
      (state_q == REQ): begin
        if (irq_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge wins over a same-cycle clear by ack.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (take && (id_q == ID_W'(i))) pend_d[i] = 1'b0;
    end
    pend_d = pend_d | (int_e & ~prev_q);
  end

  assign mask_d = mask_we ? mask_din : mask_q;
  assign err_d  = err_q | (reti && stk_empty);

  isr_stack #(
    .DEPTH (NEST_DEPTH),
    .ID_W  (ID_W),
    .CNT_W (LVL_W)
  ) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push    (take),
    .pop     (reti),
    .push_id (id_q),
    .top_id  (top_id),
    .count   (nest_lvl),
    .empty   (stk_empty),
    .full    (stk_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      id_q    <= '0;
      vec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= int_e;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
    end
  end

  assign irq_req   = (state_q == REQ);
  assign irq_id    = id_q;
  assign irq_vec   = vec_q;
  assign err_uflow = err_q;

endmodule
